bus_decoder: RTL and testbench
==============================

# bus_decoder

Parametrised 68000 bus controller: decodes the upper address bits into `NUM_CS` prioritised active-low chip selects and applies the ROM boot overlay for the first `BOOT_CYCLES` bus cycles after reset. It generates DTACK from per-region wait-state counts or passes external DTACK through, and raises BERR on bus timeout. It sits between the CPU bus strobes and every memory/peripheral select on the board, and also drives the heartbeat LED.

## Interface
Parameters:
- `NUM_CS`, 4 — number of chip-select regions; region 0 is boot ROM.
- `ADDR_HI`, 23 / `ADDR_LO`, 16 — decoded address slice; `AW = ADDR_HI-ADDR_LO+1`.
- `CS_BASE`, {8'h00,8'h3E,8'h3C,8'h38} — packed `NUM_CS*AW` match values, region 0 in the LSBs.
- `CS_MASK`, {8'h00,8'hFE,8'hFE,8'hFC} — packed per-region compare masks; 1 = bit compared, all-zero = catch-all.
- `CS_WAIT`, {4'd1,4'hF,4'hF,4'd2} — packed 4-bit wait states per region; `4'hF` = external DTACK.
- `BOOT_CYCLES`, 8 — completed bus cycles before the overlay ends; range 1..255.
- `TIMEOUT`, 64 — clocks with AS low before BERR; range 2..1023.
- `LED_BIT`, 20 — heartbeat counter bit driving `LED_BLUE`.

Ports:
- `CLK` in 1 — CPU clock.
- `RST` in 1 — reset, asynchronous, active-low.
- `AS` in 1 — address strobe, active-low, synchronous to `CLK`.
- `IACK` in 1 — interrupt-acknowledge cycle, active-low.
- `ADDR` in AW — `ADDR[ADDR_HI:ADDR_LO]`.
- `DTACK_IN` in 1 — wired-OR external DTACK, active-low.
- `CS_N` out NUM_CS — chip selects, active-low.
- `DTACK` out 1 — DTACK to CPU, active-low.
- `BERR` out 1 — bus error, active-low.
- `VPA` out 1 — autovector request, active-low.
- `LED_BLUE` out 1 — heartbeat.

## Operation
- Match i: `((ADDR ^ CS_BASE[i]) & CS_MASK[i]) == 0`. Only the lowest-index matching region is selected. No match selects nothing; the timeout then produces BERR.
- `CS_N[i]` is combinational and low only while `~AS & IACK` and region i is selected.
- Boot overlay: while `boot==0`, every non-IACK cycle selects region 0 only, regardless of address. All other regions are held high.
- Boot counter: 8-bit, increments on each AS low→high edge, saturates. `boot` is set on the edge at which the count reaches `BOOT_CYCLES` and stays set until reset.
- FSM states:
  - IDLE → WAIT on a clock edge with AS low. This edge loads the wait counter with `CS_WAIT[sel]` and clears the timeout counter.
  - WAIT → ACK when the internal wait count reaches 0, or, for external regions, when `DTACK_IN` is sampled low.
  - WAIT → BERR when the timeout counter reaches `TIMEOUT-1`.
  - ACK/BERR → IDLE on a clock edge with AS high.
  - WAIT → IDLE if AS rises, which aborts the cycle.
- `DTACK = ~(state==ACK & ~AS)`; `BERR = ~(state==BERR & ~AS)`. Both release combinationally when AS rises.
- ACK and BERR are mutually exclusive. If DTACK arrives on the same edge the timeout expires, ACK wins.
- IACK cycles use external DTACK semantics, except as modified by `AUTOVEC_EN`.
- Heartbeat: free-running `(LED_BIT+1)`-bit counter; `LED_BLUE = cnt[LED_BIT]`.
- Reset values:
  - state IDLE, `boot=0`, all counters 0.
  - `CS_N` all high, `DTACK=1`, `BERR=1`, `VPA=1`, `LED_BLUE=0`.
- Reset asserted mid-cycle: all state clears immediately and the overlay re-engages.

## Timing
- Chip-select latency: 0 clocks, combinational from AS/ADDR.
- Internal DTACK: low after the edge `CS_WAIT+1` edges after AS is first sampled low. Wait 0 gives DTACK on the first edge.
- External DTACK: 1 clock of register latency after `DTACK_IN` is sampled low.
- BERR: low after exactly `TIMEOUT` edges with AS low and no acknowledge.
- Back-to-back cycles: AS high for at least one edge returns the FSM to IDLE. The next AS low starts a fresh count.

## Configuration
- `BUS_DECODER_AUTOVEC_EN` defined: IACK cycles drive `VPA` low while `~AS & ~IACK`. They suppress DTACK and are excluded from the timeout.
- Undefined: `VPA` is tied high. IACK cycles wait for `DTACK_IN` and are subject to timeout.

## Structure
- `bus_decoder_pkg` holds:
  - the FSM state enum (IDLE, WAIT, ACK, BERR);
  - `WAIT_EXT = 4'hF`;
  - the default base/mask/wait constants for the Mackerel memory map.
- Sub-module `region_match`: one comparator per region, instantiated `NUM_CS` times in a generate loop, feeding a priority encoder in the top.

## Test plan
- Reset, then 8 reads at 0x100000 → `CS_N[0]` low on each read. Read 9 at 0x100000 → `CS_N[3]` low and `CS_N[0]` high.
- After boot, read at 0x380000 → `CS_N[0]` low; DTACK low 3 edges after AS sampled low; DTACK releases with AS.
- After boot, read at 0x3C0000 with `DTACK_IN` held high → no DTACK; BERR low on edge 64; BERR high after AS rises.
- Read at 0x3E0000 with `DTACK_IN` low on edge 4 → DTACK low on edge 5; BERR stays high.
- IACK cycle with the macro defined → `VPA` low, `CS_N` all high, DTACK high. Macro undefined → `VPA` high and BERR at 64.
- Assert RST mid-WAIT → outputs go to reset values asynchronously, and the next cycle at 0x000000 selects ROM.

Source files
------------

// File: rtl/bus_decoder_pkg.sv
// bus_decoder_pkg: shared types and constants for the 68000 bus controller.
//   state_t     - bus-cycle FSM states
//   ack_src_t   - how the current cycle is acknowledged
//   WAIT_EXT    - wait-state code meaning "external DTACK"
//   MACKEREL_*  - default chip-select map (region 0 in the LSBs)
package bus_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } state_t;

  typedef enum logic [1:0] {
    SRC_INT,   // internal wait-state counter
    SRC_EXT,   // DTACK_IN from the peripheral
    SRC_NONE   // nothing answers; only the timeout ends the cycle
  } ack_src_t;

  localparam logic [3:0] WAIT_EXT = 4'hF;
  localparam int         TIMER_W  = 10;

  // Mackerel map: 0x38-0x3B boot ROM, 0x3C-0x3D and 0x3E-0x3F external, rest RAM.
  localparam logic [31:0] MACKEREL_CS_BASE = {8'h00, 8'h3E, 8'h3C, 8'h38};
  localparam logic [31:0] MACKEREL_CS_MASK = {8'h00, 8'hFE, 8'hFE, 8'hFC};
  localparam logic [15:0] MACKEREL_CS_WAIT = {4'd1, 4'hF, 4'hF, 4'd2};

endpackage

// File: rtl/bus_decoder_if.sv
// bus_decoder_if: CPU-side bus strobes and decoder outputs.
//   AS, IACK, ADDR, DTACK_IN  - driven by the CPU/board (master)
//   CS_N, DTACK, BERR, VPA    - driven by the decoder (slave)
interface bus_decoder_if #(
  parameter int NUM_CS = 4,
  parameter int AW     = 8
) ();
  logic              AS;
  logic              IACK;
  logic [AW-1:0]     ADDR;
  logic              DTACK_IN;
  logic [NUM_CS-1:0] CS_N;
  logic              DTACK;
  logic              BERR;
  logic              VPA;

  modport master (
    output AS, IACK, ADDR, DTACK_IN,
    input  CS_N, DTACK, BERR, VPA
  );

  modport slave (
    input  AS, IACK, ADDR, DTACK_IN,
    output CS_N, DTACK, BERR, VPA
  );
endinterface

// File: rtl/region_match.sv
// region_match: single chip-select region comparator.
//   addr  in AW - decoded upper address slice
//   match out 1 - high when every masked bit of addr equals BASE
// An all-zero MASK makes the region a catch-all.
module region_match #(
  parameter int            AW   = 8,
  parameter logic [AW-1:0] BASE = '0,
  parameter logic [AW-1:0] MASK = '0
) (
  input  logic [AW-1:0] addr,
  output logic          match
);
  assign match = ((addr ^ BASE) & MASK) == '0;
endmodule

// File: rtl/bus_decoder.sv
// bus_decoder: 68000 bus controller. Prioritised active-low chip selects,
// boot ROM overlay for the first BOOT_CYCLES bus cycles, DTACK generation
// from wait states or external DTACK, bus-timeout BERR, heartbeat LED.
//   CLK       in  - CPU clock
//   RST       in  - asynchronous active-low reset
//   bus       slave modport of bus_decoder_if (AS, IACK, ADDR, DTACK_IN in;
//             CS_N, DTACK, BERR, VPA out)
//   LED_BLUE  out - heartbeat, bit LED_BIT of a free-running counter
// Build option: BUS_DECODER_AUTOVEC_EN - IACK cycles get VPA instead of DTACK
// and are never timed out. Undefined: VPA held high, IACK waits for DTACK_IN.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int NUM_CS  = 4,
  parameter int ADDR_HI = 23,
  parameter int ADDR_LO = 16,
  parameter logic [NUM_CS*(ADDR_HI-ADDR_LO+1)-1:0] CS_BASE = MACKEREL_CS_BASE,
  parameter logic [NUM_CS*(ADDR_HI-ADDR_LO+1)-1:0] CS_MASK = MACKEREL_CS_MASK,
  parameter logic [NUM_CS*4-1:0]                   CS_WAIT = MACKEREL_CS_WAIT,
  parameter int BOOT_CYCLES = 8,
  parameter int TIMEOUT     = 64,
  parameter int LED_BIT     = 20
) (
  input  logic         CLK,
  input  logic         RST,
  bus_decoder_if.slave bus,
  output logic         LED_BLUE
);

  localparam int                 AW        = ADDR_HI - ADDR_LO + 1;
  localparam logic [TIMER_W-1:0] TO_LAST   = TIMER_W'(TIMEOUT - 2);
  localparam logic [7:0]         BOOT_LAST = 8'(BOOT_CYCLES);

  logic [NUM_CS-1:0]  match;
  logic [NUM_CS-1:0]  sel_oh;
  logic [3:0]         sel_wait;
  logic               hit;
  logic               cycle_live;
  logic               autovec_iack;
  ack_src_t           start_src;

  state_t             state, state_next;
  ack_src_t           src, src_next;
  logic [3:0]         wait_cnt, wait_next;
  logic [TIMER_W-1:0] to_cnt, to_next;
  logic               dtack_q;
  logic               as_q;
  logic [7:0]         boot_cnt;
  logic               boot;
  logic [LED_BIT:0]   hb_cnt;

  for (genvar i = 0; i < NUM_CS; i++) begin : g_match
    region_match #(
      .AW  (AW),
      .BASE(CS_BASE[i*AW +: AW]),
      .MASK(CS_MASK[i*AW +: AW])
    ) u_region_match (
      .addr (bus.ADDR),
      .match(match[i])
    );
  end

  // Priority encoder: scanning from the top down leaves the lowest match.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    hit      = 1'b0;
    sel_oh   = '0;
    sel_wait = WAIT_EXT;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit       = 1'b1;
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
        sel_wait  = CS_WAIT[i*4 +: 4];
      end
    end
    // Boot overlay: ROM answers at every address until boot completes.
    if (!boot) begin
      hit      = 1'b1;
      sel_oh   = NUM_CS'(1);
      sel_wait = CS_WAIT[3:0];
    end
  end

  // Gating with RST forces all selects inactive the instant reset asserts,
  // even though the re-engaged overlay would otherwise select ROM.
  assign cycle_live = RST & ~bus.AS;
  assign bus.CS_N   = ~(sel_oh & {NUM_CS{cycle_live & bus.IACK}});

`ifdef BUS_DECODER_AUTOVEC_EN
  assign autovec_iack = ~bus.IACK;
  assign bus.VPA      = ~(cycle_live & ~bus.IACK);
`else
  assign autovec_iack = 1'b0;
  assign bus.VPA      = 1'b1;
`endif

  always_comb begin
    if (!bus.IACK)                start_src = SRC_EXT;
    else if (!hit)                start_src = SRC_NONE;
    else if (sel_wait == WAIT_EXT) start_src = SRC_EXT;
    else                          start_src = SRC_INT;
  end

  always_comb begin
    state_next = state;
    src_next   = src;
    wait_next  = wait_cnt;
    to_next    = to_cnt;
    case (state)
      ST_IDLE: begin
        // Autovectored IACK cycles never leave IDLE: no DTACK, no timeout.
        if (!bus.AS && !autovec_iack) begin
          src_next   = start_src;
          wait_next  = sel_wait;
          to_next    = '0;
          state_next = (start_src == SRC_INT && sel_wait == 4'd0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.AS) begin
          state_next = ST_IDLE;
        end else begin
          to_next = to_cnt + TIMER_W'(1);
          if (src == SRC_INT) wait_next = wait_cnt - 4'd1;
          // Count "reaches 0" on this edge when it is 1 now; ACK beats timeout.
          if ((src == SRC_INT && wait_cnt == 4'd1) || (src == SRC_EXT && !dtack_q))
            state_next = ST_ACK;
          else if (to_cnt == TO_LAST)
            state_next = ST_BERR;
        end
      end
      ST_ACK, ST_BERR: begin
        if (bus.AS) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      src      <= SRC_INT;
      wait_cnt <= '0;
      to_cnt   <= '0;
      dtack_q  <= 1'b1;
    end else begin
      state    <= state_next;
      src      <= src_next;
      wait_cnt <= wait_next;
      to_cnt   <= to_next;
      dtack_q  <= bus.DTACK_IN;
    end
  end

  assign bus.DTACK = ~(state == ST_ACK  && !bus.AS);
  assign bus.BERR  = ~(state == ST_BERR && !bus.AS);

  // Boot counter advances on each completed bus cycle (AS low->high).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      as_q     <= 1'b1;
      boot_cnt <= '0;
      boot     <= 1'b0;
    end else begin
      as_q <= bus.AS;
      if (!as_q && bus.AS) begin
        if (boot_cnt != 8'hFF) boot_cnt <= boot_cnt + 8'd1;
        if (boot_cnt + 8'd1 == BOOT_LAST) boot <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) hb_cnt <= '0;
    else      hb_cnt <= hb_cnt + (LED_BIT + 1)'(1);
  end

  assign LED_BLUE = hb_cnt[LED_BIT];

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: randomized self-checking bench for bus_decoder. The reference
// model works per bus cycle: it picks the region from the memory-map rules and
// computes on which edge DTACK or BERR must appear, then checks every edge.
module tb_bus_decoder;

  localparam int TIMEOUT = 64;
  localparam int BOOT    = 8;
  localparam int LED_BIT = 4;

`ifdef BUS_DECODER_AUTOVEC_EN
  localparam bit AUTOVEC = 1'b1;
`else
  localparam bit AUTOVEC = 1'b0;
`endif

  localparam logic [7:0] MAP_BASE [4] = '{8'h38, 8'h3C, 8'h3E, 8'h00};
  localparam logic [7:0] MAP_MASK [4] = '{8'hFC, 8'hFE, 8'hFE, 8'h00};
  localparam int         MAP_WAIT [4] = '{2, 15, 15, 1};

  logic CLK = 1'b0;
  logic RST;
  logic LED_BLUE;

  bus_decoder_if #(.NUM_CS(4), .AW(8)) bus ();

  bus_decoder #(.LED_BIT(LED_BIT)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .bus     (bus),
    .LED_BLUE(LED_BLUE)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  int boot_done;
  int hb;

  always @(posedge CLK or negedge RST) begin
    if (!RST) hb <= 0;
    else      hb <= hb + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Region the rules select, -1 for none.
  function automatic int exp_region(input logic [7:0] a, input bit iack);
    if (iack) return -1;
    if (boot_done < BOOT) return 0;
    for (int i = 0; i < 4; i++)
      if (((a ^ MAP_BASE[i]) & MAP_MASK[i]) == 8'h00) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_csn(input int r);
    logic [3:0] v;
    v = 4'hF;
    if (r >= 0) v[r] = 1'b0;
    return v;
  endfunction

  // One bus cycle. Called right after a falling edge. hold = edges with AS low,
  // dt_edge = edge on which DTACK_IN is first sampled low (0 = never).
  task automatic bus_cycle(input logic [7:0] a, input bit iack, input int hold, input int dt_edge);
    int r, ack_edge, berr_edge;
    bit av;
    logic [3:0] csn;
    av        = iack && AUTOVEC;
    r         = exp_region(a, iack);
    csn       = exp_csn(r);
    ack_edge  = 0;
    berr_edge = 0;
    if (!av) begin
      if (iack || (r >= 0 && MAP_WAIT[r] == 15))
        ack_edge = (dt_edge != 0) ? dt_edge + 1 : 0;
      else if (r >= 0)
        ack_edge = MAP_WAIT[r] + 1;
      if (ack_edge == 0 || ack_edge > TIMEOUT) begin
        ack_edge  = 0;
        berr_edge = TIMEOUT;
      end
    end

    bus.ADDR     = a;
    bus.IACK     = ~iack;
    bus.DTACK_IN = (dt_edge == 1) ? 1'b0 : 1'b1;
    bus.AS       = 1'b0;
    #1;
    check("cs_n_start", bus.CS_N, csn);
    check("vpa_start", bus.VPA, av ? 1'b0 : 1'b1);
    for (int k = 1; k <= hold; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("dtack", bus.DTACK, (ack_edge != 0 && k >= ack_edge) ? 1'b0 : 1'b1);
      check("berr", bus.BERR, (berr_edge != 0 && k >= berr_edge) ? 1'b0 : 1'b1);
      check("cs_n", bus.CS_N, csn);
      check("vpa", bus.VPA, av ? 1'b0 : 1'b1);
      check("led", LED_BLUE, (hb >> LED_BIT) & 1);
      if (dt_edge != 0 && k + 1 >= dt_edge) bus.DTACK_IN = 1'b0;
    end
    bus.AS       = 1'b1;
    bus.DTACK_IN = 1'b1;
    #1;
    check("dtack_release", bus.DTACK, 1'b1);
    check("berr_release", bus.BERR, 1'b1);
    check("cs_n_release", bus.CS_N, 4'hF);
    check("vpa_release", bus.VPA, 1'b1);
    @(posedge CLK);
    boot_done++;
    @(negedge CLK);
  endtask

  initial begin
    logic [7:0] a;
    bit         iack;
    int         hold, dt;

    RST          = 1'b0;
    bus.AS       = 1'b1;
    bus.IACK     = 1'b1;
    bus.ADDR     = 8'h00;
    bus.DTACK_IN = 1'b1;
    boot_done    = 0;
    #1;
    check("rst_cs_n", bus.CS_N, 4'hF);
    check("rst_dtack", bus.DTACK, 1'b1);
    check("rst_berr", bus.BERR, 1'b1);
    check("rst_vpa", bus.VPA, 1'b1);
    check("rst_led", LED_BLUE, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // Boot overlay: eight ROM reads at a RAM address, then RAM takes over.
    for (int i = 0; i < 9; i++) bus_cycle(8'h10, 1'b0, 4, 0);
    // Internal ROM wait states, external timeout, external ack.
    bus_cycle(8'h38, 1'b0, 5, 0);
    bus_cycle(8'h3C, 1'b0, 70, 0);
    bus_cycle(8'h3E, 1'b0, 8, 4);
    // DTACK on the timeout edge wins; one edge later BERR wins.
    bus_cycle(8'h3D, 1'b0, 66, 63);
    bus_cycle(8'h3F, 1'b0, 66, 64);
    // Interrupt acknowledge.
    bus_cycle(8'h55, 1'b1, 70, 0);
    bus_cycle(8'hAA, 1'b1, 8, 3);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0:       a = 8'($urandom);
        1:       a = 8'h38 | 8'($urandom_range(0, 3));
        2:       a = 8'h3C | 8'($urandom_range(0, 1));
        default: a = 8'h3E | 8'($urandom_range(0, 1));
      endcase
      iack = ($urandom_range(0, 7) == 0);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(60, 68) : $urandom_range(1, 10);
      dt   = $urandom_range(0, 9);
      bus_cycle(a, iack, hold, dt);
    end

    // Reset in the middle of a cycle: everything releases at once.
    bus.ADDR     = 8'h38;
    bus.IACK     = 1'b1;
    bus.DTACK_IN = 1'b1;
    bus.AS       = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("pre_rst_cs_n", bus.CS_N, 4'hE);
    RST = 1'b0;
    #1;
    check("mid_rst_cs_n", bus.CS_N, 4'hF);
    check("mid_rst_dtack", bus.DTACK, 1'b1);
    check("mid_rst_berr", bus.BERR, 1'b1);
    check("mid_rst_led", LED_BLUE, 1'b0);
    @(posedge CLK);
    @(negedge CLK);
    check("in_rst_dtack", bus.DTACK, 1'b1);
    bus.AS = 1'b1;
    @(negedge CLK);
    RST       = 1'b1;
    boot_done = 0;
    bus_cycle(8'h00, 1'b0, 4, 0);
    bus_cycle(8'h3C, 1'b0, 4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
